// File: rtl/adder_serial_if.sv
// Request/result bundle for the digit-serial adder/subtractor.
// The master side issues operations and the slave side returns results.
interface adder_serial_if #(
   parameter int WIDTH = 8
) ();
   logic             i_start;
   logic [WIDTH-1:0] i_a;
   logic [WIDTH-1:0] i_b;
   logic             i_carry;
   logic             i_mode;
   logic             o_busy;
   logic             o_done;
   logic [WIDTH-1:0] o_sum;
   logic             o_carry;
   logic             o_overflow;

   modport master (
      output i_start, i_a, i_b, i_carry, i_mode,
      input  o_busy, o_done, o_sum, o_carry, o_overflow
   );

   modport slave (
      input  i_start, i_a, i_b, i_carry, i_mode,
      output o_busy, o_done, o_sum, o_carry, o_overflow
   );
endinterface

// File: rtl/adder_serial.sv
// Digit-serial adder/subtractor: DIGIT bits per RUN cycle, LSB first, with a
// three-state IDLE/RUN/DONE controller and held result registers.
module adder_serial #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic          clk,
   input  logic          rst,
   adder_serial_if.slave bus
);
   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] a_sh, b_sh, acc, acc_next;
   logic             c;
   logic [CW-1:0]    cnt;
   logic             accept, last;
   logic [DIGIT:0]   dsum;
   logic             ovf_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // NOTE: every output of this block gets a default first so no path leaves
   // a signal unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      last       = 1'b0;
      bus.o_busy = (state != IDLE);
      bus.o_done = (state == DONE);
      case (state)
         IDLE: if (bus.i_start) begin
            accept     = 1'b1;
            state_next = RUN;
         end
         RUN: if (cnt == CW'(NDIG - 1)) begin
            last       = 1'b1;
            state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // One digit of the ripple sum; the new digit enters the accumulator at the
   // top so that after NDIG shifts the first digit sits at bit 0.
   always_comb begin
      dsum     = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + (DIGIT+1)'(c);
      acc_next = (acc >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
      // Same-sign operands producing an opposite-sign result; equivalent to
      // carry-into-MSB XOR carry-out-of-MSB on the last digit.
      ovf_next = (a_sh[DIGIT-1] == b_sh[DIGIT-1]) && (dsum[DIGIT-1] != a_sh[DIGIT-1]);
   end

   // NOTE: state is written with non-blocking assignments so every register
   // in this block samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh           <= '0;
         b_sh           <= '0;
         acc            <= '0;
         c              <= 1'b0;
         cnt            <= '0;
         bus.o_sum      <= '0;
         bus.o_carry    <= 1'b0;
         bus.o_overflow <= 1'b0;
      end else if (accept) begin
         // Subtraction is A + ~B + ~borrow, so o_carry reads 1 for no borrow.
         a_sh <= bus.i_a;
         b_sh <= bus.i_mode ? ~bus.i_b : bus.i_b;
         c    <= bus.i_mode ? ~bus.i_carry : bus.i_carry;
         acc  <= '0;
         cnt  <= '0;
      end else if (state == RUN) begin
         a_sh <= a_sh >> DIGIT;
         b_sh <= b_sh >> DIGIT;
         c    <= dsum[DIGIT];
         acc  <= acc_next;
         cnt  <= last ? '0 : cnt + CW'(1);
         if (last) begin
            bus.o_sum      <= acc_next;
            bus.o_carry    <= dsum[DIGIT];
            bus.o_overflow <= ovf_next;
         end
      end
   end
endmodule

// File: tb/tb_adder_serial.sv
// Directed and randomised bench for adder_serial at WIDTH=8 with DIGIT=2, 1, 8
// instances sharing one stimulus, plus a back-to-back run on the DIGIT=2 unit.
module tb_adder_serial;
   typedef struct packed {
      logic [7:0] sum;
      logic       carry;
      logic       ovf;
   } res_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] a = '0, b = '0;
   logic       cin = 1'b0, mode = 1'b0;
   int         cyc = 0;
   int         n_checks = 0;
   int         n_fails = 0;

   string names[3]   = '{"d2", "d1", "d8"};
   int    lat_exp[3] = '{5, 9, 2};

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   adder_serial_if #(.WIDTH(8)) bus2 ();
   adder_serial_if #(.WIDTH(8)) bus1 ();
   adder_serial_if #(.WIDTH(8)) bus8 ();

   assign bus2.i_start = start; assign bus2.i_a = a; assign bus2.i_b = b;
   assign bus2.i_carry = cin;   assign bus2.i_mode = mode;
   assign bus1.i_start = start; assign bus1.i_a = a; assign bus1.i_b = b;
   assign bus1.i_carry = cin;   assign bus1.i_mode = mode;
   assign bus8.i_start = start; assign bus8.i_a = a; assign bus8.i_b = b;
   assign bus8.i_carry = cin;   assign bus8.i_mode = mode;

   adder_serial #(.WIDTH(8), .DIGIT(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
   adder_serial #(.WIDTH(8), .DIGIT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   adder_serial #(.WIDTH(8), .DIGIT(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic res_t model(input logic [7:0] x, y, input logic ci, m);
      logic [8:0] t;
      res_t       r;
      if (!m) t = {1'b0, x} + {1'b0, y} + (ci ? 9'd1 : 9'd0);
      else    t = {1'b0, x} - {1'b0, y} - (ci ? 9'd1 : 9'd0);
      r.sum   = t[7:0];
      // For subtract, bit 8 of the 9-bit difference is the borrow.
      r.carry = m ? ~t[8] : t[8];
      r.ovf   = m ? ((x[7] != y[7]) && (t[7] != x[7]))
                  : ((x[7] == y[7]) && (t[7] != x[7]));
      return r;
   endfunction

   task automatic grab(input int i, output logic busy, output logic done, output res_t r);
      case (i)
         0: begin busy = bus2.o_busy; done = bus2.o_done; r = {bus2.o_sum, bus2.o_carry, bus2.o_overflow}; end
         1: begin busy = bus1.o_busy; done = bus1.o_done; r = {bus1.o_sum, bus1.o_carry, bus1.o_overflow}; end
         default: begin busy = bus8.o_busy; done = bus8.o_done; r = {bus8.o_sum, bus8.o_carry, bus8.o_overflow}; end
      endcase
   endtask

   // One operation on all three units; inputs are scrambled after capture and
   // an optional extra start pulse is raised during cycle 'glitch'.
   task automatic run_op(input string tag, input logic [7:0] ta, tb_v,
                         input logic tc, tm, input int glitch);
      res_t e, r;
      res_t got[3];
      int   lat[3], nd[3];
      logic bz, d;
      e = model(ta, tb_v, tc, tm);
      for (int i = 0; i < 3; i++) begin lat[i] = 0; nd[i] = 0; got[i] = '0; end
      @(posedge clk); #1;
      a = ta; b = tb_v; cin = tc; mode = tm; start = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         @(posedge clk); #1;
         start = (k == glitch);
         a = 8'($urandom); b = 8'($urandom);
         cin = 1'($urandom); mode = 1'($urandom);
         for (int i = 0; i < 3; i++) begin
            grab(i, bz, d, r);
            if (d) begin
               nd[i]++;
               if (nd[i] == 1) begin lat[i] = k; got[i] = r; end
            end
         end
      end
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("%s/%s latency", tag, names[i]), lat[i], lat_exp[i]);
         check($sformatf("%s/%s done_pulses", tag, names[i]), nd[i], 1);
         check($sformatf("%s/%s sum", tag, names[i]), got[i].sum, e.sum);
         check($sformatf("%s/%s carry", tag, names[i]), got[i].carry, e.carry);
         check($sformatf("%s/%s overflow", tag, names[i]), got[i].ovf, e.ovf);
      end
      check($sformatf("%s/d2 held_sum", tag), bus2.o_sum, e.sum);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      res_t e, r;
      logic bz, d;
      int   nd[3];
      int   w, last_cyc;

      // Reset values.
      #12;
      for (int i = 0; i < 3; i++) begin
         grab(i, bz, d, r);
         check($sformatf("reset/%s busy", names[i]), bz, 0);
         check($sformatf("reset/%s done", names[i]), d, 0);
         check($sformatf("reset/%s result", names[i]), r, 0);
      end
      rst = 1'b0;

      // Directed vectors.
      run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 0);   // 00 c1 v0
      run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 0);   // 80 c0 v1
      run_op("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 0);   // FE c0 v0
      run_op("add_aa_55", 8'hAA, 8'h55, 1'b1, 1'b0, 0);   // 00 c1 v0
      run_op("add_00_ci", 8'h00, 8'h00, 1'b1, 1'b0, 0);   // 01 c0 v0
      run_op("sub_10_bi", 8'h10, 8'h01, 1'b1, 1'b1, 0);   // 0E c1 v0
      run_op("ign_start", 8'h3C, 8'h4B, 1'b0, 1'b0, 2);   // 87 c0 v1
      run_op("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 0);   // 7F c1 v1

      // Reset during RUN (d2, d1) and during DONE (d8).
      @(posedge clk); #1;
      a = 8'h12; b = 8'h34; cin = 1'b0; mode = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         grab(i, bz, d, r);
         check($sformatf("midrst/%s busy", names[i]), bz, 0);
         check($sformatf("midrst/%s done", names[i]), d, 0);
         check($sformatf("midrst/%s result", names[i]), r, 0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) nd[i] = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         for (int i = 0; i < 3; i++) begin
            grab(i, bz, d, r);
            if (d) nd[i]++;
         end
      end
      for (int i = 0; i < 3; i++)
         check($sformatf("midrst/%s no_done", names[i]), nd[i], 0);
      run_op("post_rst", 8'h12, 8'h34, 1'b0, 1'b0, 0);

      // Randomised single operations on all three digit sizes.
      for (int n = 0; n < 120; n++)
         run_op($sformatf("rnd%0d", n), 8'($urandom), 8'($urandom),
                1'($urandom), 1'($urandom), 0);

      // Back-to-back on d2 with start held high: one result every 6 cycles.
      @(posedge clk); #1;
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); mode = 1'($urandom);
      e = model(a, b, cin, mode);
      start = 1'b1;
      last_cyc = 0;
      for (int k = 0; k < 300; k++) begin
         w = 0;
         do begin
            @(posedge clk); #1;
            w++;
         end while (!bus2.o_done && w < 20);
         check($sformatf("b2b%0d done_seen", k), bus2.o_done, 1);
         check($sformatf("b2b%0d sum", k), bus2.o_sum, e.sum);
         check($sformatf("b2b%0d carry", k), bus2.o_carry, e.carry);
         check($sformatf("b2b%0d overflow", k), bus2.o_overflow, e.ovf);
         if (k > 0) check($sformatf("b2b%0d spacing", k), cyc - last_cyc, 6);
         last_cyc = cyc;
         a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); mode = 1'($urandom);
         e = model(a, b, cin, mode);
      end
      start = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
